rfe_enroll_stream: RTL and testbench

Parametrised fuzzy-extractor enrollment engine, successor to the single-shot helper generator. Reads PUF response words over a configurable-width bus and draws TRNG bits per block. Encodes each block with RM(1,M) and streams (R', H = R' XOR Enc(x)) one block at a time over a valid/ready interface. This removes the BLOCKS*N-wide output registers. Sits between the PUF/TRNG macros and the helper-data NVM writer.

---
 rtl/rfe_pkg.sv | 33 +++
 rtl/rm1m_encoder.sv | 24 ++
 rtl/rfe_enroll_stream.sv | 188 ++++++++++++++++++
 tb/tb_rfe_enroll_stream.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rfe_pkg.sv
// Shared types and helpers for the fuzzy-extractor enrollment stream.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM state enum, TRNG mode encodings, a clog2 that never returns 0, and an RM(1,M) bit model.
package rfe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUF_READ,
        ST_TRNG_READ,
        ST_ENC,
        ST_OUT,
        ST_DONE
    } rfe_state_t;

    localparam int TRNG_MODE_REP   = 0;  // one TRNG bit per block, copied into every x bit
    localparam int TRNG_MODE_FRESH = 1;  // K fresh TRNG bits per block, a[0] first

    // Width helper: at least one bit even for a count of 0 or 1.
    function automatic int clog2_safe(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // Reference RM(1,m) codeword bit u for message a (a[0] is the constant term).
    function automatic logic rm_cw(input int m, input logic [6:0] a, input int u);
        logic r;
        r = a[0];
        for (int j = 0; j < m; j++) begin
            r = r ^ (a[j+1] & u[j]);
        end
        return r;
    endfunction

endpackage

// File: rtl/rm1m_encoder.sv
// RM(1,M) encoder: codeword[u] = a[0] ^ XOR_j(a[j+1] & u[j]).
// Latency: purely combinational. Backpressure: none.
// Ports: a[K-1:0] message in, codeword[N-1:0] out. Each bit is an AND row feeding an M-deep XOR chain.
module rm1m_encoder #(
    parameter int  M = 5,
    localparam int N = 1 << M,
    localparam int K = M + 1
) (
    input  logic [K-1:0] a,
    output logic [N-1:0] codeword
);

    for (genvar u = 0; u < N; u++) begin : g_bit
        localparam logic [M-1:0] UB = M'(u);
        logic [M:0] acc;

        assign acc[0] = a[0];
        for (genvar j = 0; j < M; j++) begin : g_term
            assign acc[j+1] = acc[j] ^ (a[j+1] & UB[j]);
        end
        assign codeword[u] = acc[M];
    end

endmodule

// File: rtl/rfe_enroll_stream.sv
// Fuzzy-extractor enrollment: reads PUF words and TRNG bits, streams one (R', H = R' ^ RM(1,M)(x)) block at a time.
// Latency: first out_valid 2 + 2*PUF_WORDS + 2*TB edges after start; each later block 2*TB + 2 after the previous handshake.
// Backpressure: out_* held stable while out_valid & ~out_ready; nothing advances until the handshake.
// Ports: start/abort/busy/done control; puf_clk/puf_enable/puf_addr/puf_data PUF bus; trng_clk/trng_enable/trng_data
// TRNG bus; out_valid/out_ready/out_index/out_last/out_helper block stream; out_rprime only with RFE_RPRIME_OUT_EN.
module rfe_enroll_stream
    import rfe_pkg::*;
#(
    parameter int  M          = 5,
    parameter int  PUF_BLOCKS = 2,
    parameter int  BLOCKS     = 22,
    parameter int  PUF_W      = 8,
    parameter int  TRNG_MODE  = TRNG_MODE_REP,
    localparam int N          = 1 << M,
    localparam int K          = M + 1,
    localparam int PUF_WORDS  = PUF_BLOCKS * N / PUF_W,
    localparam int AW         = clog2_safe(PUF_WORDS),
    localparam int IW         = clog2_safe(BLOCKS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             puf_clk,
    output logic             puf_enable,
    output logic [AW-1:0]    puf_addr,
    input  logic [PUF_W-1:0] puf_data,
    output logic             trng_clk,
    output logic             trng_enable,
    input  logic             trng_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_index,
    output logic             out_last,
    output logic [N-1:0]     out_helper
`ifdef RFE_RPRIME_OUT_EN
   ,output logic [N-1:0]     out_rprime
`endif
);

    localparam int TB = (TRNG_MODE == TRNG_MODE_FRESH) ? K : 1;
    localparam int BW = clog2_safe(K);
    localparam int RW = clog2_safe(PUF_BLOCKS);

    rfe_state_t              state;
    logic                    start_d;
    logic [PUF_BLOCKS*N-1:0] pbuf;
    logic [K-1:0]            x_q;
    logic [BW-1:0]           bit_cnt;
    logic [IW-1:0]           blk;
    logic [RW-1:0]           rsel;    // blk % PUF_BLOCKS, kept as a wrapping counter to avoid a divider
    logic [N-1:0]            cw;
    logic [N-1:0]            r_cur;

    assign r_cur = pbuf[rsel*N +: N];

    rm1m_encoder #(.M(M)) u_enc (
        .a        (x_q),
        .codeword (cw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            start_d     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            puf_clk     <= 1'b0;
            puf_enable  <= 1'b0;
            puf_addr    <= '0;
            trng_clk    <= 1'b0;
            trng_enable <= 1'b0;
            out_valid   <= 1'b0;
            out_index   <= '0;
            out_last    <= 1'b0;
            out_helper  <= '0;
`ifdef RFE_RPRIME_OUT_EN
            out_rprime  <= '0;
`endif
            pbuf        <= '0;
            x_q         <= '0;
            bit_cnt     <= '0;
            blk         <= '0;
            rsel        <= '0;
        end else begin
            start_d <= start;
            done    <= 1'b0;
            if (abort && state != ST_IDLE) begin
                // Abort wins over everything, including a same-cycle handshake; pbuf is kept.
                state       <= ST_IDLE;
                busy        <= 1'b0;
                puf_clk     <= 1'b0;
                puf_enable  <= 1'b0;
                puf_addr    <= '0;
                trng_clk    <= 1'b0;
                trng_enable <= 1'b0;
                out_valid   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !start_d) begin
                            state      <= ST_PUF_READ;
                            busy       <= 1'b1;
                            puf_enable <= 1'b1;
                            puf_clk    <= 1'b0;
                            puf_addr   <= '0;
                        end
                    end
                    ST_PUF_READ: begin
                        // puf_clk doubles as the word phase: low = address phase, high = capture phase.
                        if (!puf_clk) begin
                            puf_clk <= 1'b1;
                        end else begin
                            puf_clk <= 1'b0;
                            pbuf[puf_addr*PUF_W +: PUF_W] <= puf_data;
                            if (puf_addr == AW'(PUF_WORDS - 1)) begin
                                state       <= ST_TRNG_READ;
                                puf_enable  <= 1'b0;
                                puf_addr    <= '0;
                                blk         <= '0;
                                rsel        <= '0;
                                bit_cnt     <= '0;
                                trng_enable <= 1'b1;
                                trng_clk    <= 1'b0;
                            end else begin
                                puf_addr <= puf_addr + AW'(1);
                            end
                        end
                    end
                    ST_TRNG_READ: begin
                        if (!trng_clk) begin
                            trng_clk <= 1'b1;
                        end else begin
                            trng_clk <= 1'b0;
                            if (TRNG_MODE == TRNG_MODE_FRESH) begin
                                x_q[bit_cnt] <= trng_data;
                            end else begin
                                x_q <= {K{trng_data}};
                            end
                            if (bit_cnt == BW'(TB - 1)) begin
                                state       <= ST_ENC;
                                trng_enable <= 1'b0;
                                bit_cnt     <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end
                    ST_ENC: begin
                        out_helper <= r_cur ^ cw;
`ifdef RFE_RPRIME_OUT_EN
                        out_rprime <= r_cur;
`endif
                        out_index  <= blk;
                        out_last   <= (blk == IW'(BLOCKS - 1));
                        out_valid  <= 1'b1;
                        state      <= ST_OUT;
                    end
                    ST_OUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (blk == IW'(BLOCKS - 1)) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                blk         <= blk + IW'(1);
                                rsel        <= (rsel == RW'(PUF_BLOCKS - 1)) ? '0 : rsel + RW'(1);
                                state       <= ST_TRNG_READ;
                                trng_enable <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rfe_enroll_stream.sv
// Directed bench for rfe_enroll_stream: mode-0 instance (PUF_W=8) and mode-1 instance (PUF_W=32).
// Latency: checks first-valid edge and per-block gap on the mode-0 instance.
// Backpressure: stalls out_ready for 5 cycles per block and checks that out_* hold.
module tb_rfe_enroll_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: M=5, PUF_BLOCKS=2, BLOCKS=4, PUF_W=8, TRNG_MODE=0
    logic        start_a = 1'b0, abort_a = 1'b0, out_ready_a = 1'b1;
    logic        busy_a, done_a, puf_clk_a, puf_enable_a, trng_clk_a, trng_enable_a, trng_data_a;
    logic        out_valid_a, out_last_a;
    logic [2:0]  puf_addr_a;
    logic [7:0]  puf_data_a;
    logic [1:0]  out_index_a;
    logic [31:0] out_helper_a;
`ifdef RFE_RPRIME_OUT_EN
    logic [31:0] out_rprime_a;
`endif

    // Instance B: M=5, PUF_BLOCKS=2, BLOCKS=4, PUF_W=32, TRNG_MODE=1
    logic        start_b = 1'b0, abort_b = 1'b0, out_ready_b = 1'b1;
    logic        busy_b, done_b, puf_clk_b, puf_enable_b, trng_clk_b, trng_enable_b, trng_data_b;
    logic        out_valid_b, out_last_b;
    logic [0:0]  puf_addr_b;
    logic [31:0] puf_data_b;
    logic [1:0]  out_index_b;
    logic [31:0] out_helper_b;
`ifdef RFE_RPRIME_OUT_EN
    logic [31:0] out_rprime_b;
`endif

    // PUF models: byte k of the PUF space holds value k.
    logic [7:0] pbase_b;
    assign puf_data_a = {5'd0, puf_addr_a};
    assign pbase_b    = {5'd0, puf_addr_b, 2'd0};
    assign puf_data_b = {pbase_b + 8'd3, pbase_b + 8'd2, pbase_b + 8'd1, pbase_b};

    // TRNG models: bit table walked one entry per trng_clk-high capture edge.
    logic [31:0] bits_a = 32'h0, bits_b = 32'h0;
    logic [4:0]  ptr_a = 5'd0, ptr_b = 5'd0;
    logic        ptr_clr = 1'b0;
    assign trng_data_a = bits_a[ptr_a];
    assign trng_data_b = bits_b[ptr_b];
    always @(posedge clk) begin
        if (ptr_clr) begin
            ptr_a <= 5'd0;
            ptr_b <= 5'd0;
        end else begin
            if (trng_clk_a) ptr_a <= ptr_a + 5'd1;
            if (trng_clk_b) ptr_b <= ptr_b + 5'd1;
        end
    end

    // Word addresses seen by instance B at each PUF capture edge.
    int addr_log_b[$];
    always @(posedge clk) if (puf_clk_b) addr_log_b.push_back(int'(puf_addr_b));

    rfe_enroll_stream #(.M(5), .PUF_BLOCKS(2), .BLOCKS(4), .PUF_W(8), .TRNG_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .busy(busy_a), .done(done_a),
        .puf_clk(puf_clk_a), .puf_enable(puf_enable_a), .puf_addr(puf_addr_a), .puf_data(puf_data_a),
        .trng_clk(trng_clk_a), .trng_enable(trng_enable_a), .trng_data(trng_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_index(out_index_a), .out_last(out_last_a),
        .out_helper(out_helper_a)
`ifdef RFE_RPRIME_OUT_EN
       ,.out_rprime(out_rprime_a)
`endif
    );

    rfe_enroll_stream #(.M(5), .PUF_BLOCKS(2), .BLOCKS(4), .PUF_W(32), .TRNG_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
        .puf_clk(puf_clk_b), .puf_enable(puf_enable_b), .puf_addr(puf_addr_b), .puf_data(puf_data_b),
        .trng_clk(trng_clk_b), .trng_enable(trng_enable_b), .trng_data(trng_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_index(out_index_b), .out_last(out_last_b),
        .out_helper(out_helper_b)
`ifdef RFE_RPRIME_OUT_EN
       ,.out_rprime(out_rprime_b)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mode 0, bits 1,0,1,1. R alternates 0x03020100 / 0x07060504.
    // Codeword for all-ones x is ~parity(u) per bit = 0x69969669; for all-zeros it is 0.
    logic [31:0] exp_h_a[4] = '{32'h6A949769, 32'h07060504, 32'h6A949769, 32'h6E90936D};
    logic [31:0] exp_r_a[4] = '{32'h03020100, 32'h07060504, 32'h03020100, 32'h07060504};
    // Mode 1: x = a[0] only -> all ones; a[1] -> 0xAAAAAAAA; a[5] -> 0xFFFF0000; zero.
    logic [31:0] exp_h_b[4] = '{32'hFCFDFEFF, 32'hADACAFAE, 32'hFCFD0100, 32'h07060504};

    task automatic wait_vld_a(output int n);
        n = 0;
        while (!out_valid_a && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("vld_timeout_a", out_valid_a, 1);
    endtask

    task automatic run_a(input bit stall, input bit chk_lat, input bit hold);
        int n;
        ptr_clr = 1'b1;
        tick();
        ptr_clr = 1'b0;
        out_ready_a = !stall;
        start_a = 1'b1;
        tick();                      // edge 0: start sampled
        if (!hold) start_a = 1'b0;
        for (int b = 0; b < 4; b++) begin
            wait_vld_a(n);
            if (chk_lat && b == 0) chk("first_vld_edge", n + 1, 20);
            if (chk_lat && b > 0)  chk("block_gap", n + 1, 4);
            if (stall) begin
                repeat (5) begin
                    tick();
                    chk("hold_vld", out_valid_a, 1);
                    chk("hold_h", out_helper_a, exp_h_a[b]);
                    chk("hold_idx", out_index_a, b);
                end
            end
            chk("h_a", out_helper_a, exp_h_a[b]);
            chk("idx_a", out_index_a, b);
            chk("last_a", out_last_a, (b == 3));
`ifdef RFE_RPRIME_OUT_EN
            chk("rp_a", out_rprime_a, exp_r_a[b]);
`endif
            out_ready_a = 1'b1;
            tick();                  // handshake edge
            out_ready_a = !stall;
            if (b == 3) chk("done_a", done_a, 1);
            else        chk("vld_drop_a", out_valid_a, 0);
        end
        tick();
        chk("done_end_a", done_a, 0);
        chk("busy_end_a", busy_a, 0);
    endtask

    initial begin
        int n;
        bits_a = 32'h0000000D;       // 1,0,1,1
        bits_b = 32'h00020081;       // block0 a[0]; block1 a[1]; block2 a[5]; block3 none
        repeat (3) tick();
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_vld", out_valid_a, 0);
        chk("rst_h", out_helper_a, 0);
        chk("rst_pen", puf_enable_a, 0);
        chk("rst_addr", puf_addr_a, 0);
        chk("rst_ten", trng_enable_a, 0);
        rst_n = 1'b1;
        tick();

        run_a(1'b0, 1'b1, 1'b0);     // basic run with latency checks
        run_a(1'b1, 1'b0, 1'b0);     // 5-cycle stall per block

        // Abort in the capture phase of PUF word 3.
        ptr_clr = 1'b1; tick(); ptr_clr = 1'b0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        n = 0;
        while (!(puf_clk_a && puf_addr_a == 3'd3) && n < 100) begin
            tick();
            n++;
        end
        chk("abort_reach", {puf_clk_a, puf_addr_a}, {1'b1, 3'd3});
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_pen", puf_enable_a, 0);
        chk("abort_pclk", puf_clk_a, 0);
        chk("abort_vld", out_valid_a, 0);
        repeat (4) begin
            tick();
            chk("abort_no_done", done_a, 0);
        end
        run_a(1'b0, 1'b0, 1'b0);     // a fresh start after abort

        // start held high through a run: exactly one run.
        run_a(1'b0, 1'b0, 1'b1);
        repeat (10) begin
            tick();
            chk("no_retrigger", busy_a, 0);
        end
        start_a = 1'b0;
        tick();

        // Asynchronous reset while a block is waiting in OUT.
        ptr_clr = 1'b1; tick(); ptr_clr = 1'b0;
        out_ready_a = 1'b0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_vld_a(n);
        chk("pre_rst_h", out_helper_a, exp_h_a[0]);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_a, 0);
        chk("arst_vld", out_valid_a, 0);
        chk("arst_h", out_helper_a, 0);
        chk("arst_idx_last", {out_index_a, out_last_a}, 0);
        chk("arst_en", {puf_enable_a, trng_enable_a, puf_clk_a, trng_clk_a, done_a}, 0);
        #2 rst_n = 1'b1;
        out_ready_a = 1'b1;
        tick();

        // Mode 1 with 32-bit PUF bus.
        ptr_clr = 1'b1; tick(); ptr_clr = 1'b0;
        addr_log_b.delete();
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int b = 0; b < 4; b++) begin
            n = 0;
            while (!out_valid_b && n < 200) begin
                tick();
                n++;
            end
            chk("h_b", out_helper_b, exp_h_b[b]);
            chk("idx_b", out_index_b, b);
`ifdef RFE_RPRIME_OUT_EN
            chk("rp_b", out_rprime_b, exp_r_a[b]);
`endif
            tick();
        end
        chk("done_b", done_b, 1);
        chk("addr_cnt_b", addr_log_b.size(), 2);
        if (addr_log_b.size() == 2) begin
            chk("addr0_b", addr_log_b[0], 0);
            chk("addr1_b", addr_log_b[1], 1);
        end
        tick();
        chk("busy_end_b", busy_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
